// File: rtl/replay_buffer_mc.sv
// Double-buffered multi-channel spike replay buffer: capture NUM_CH vectors per beat, replay channel-major
// after each gamma edge. Optional build macro REPLAY_ZERO_SKIP_EN skips all-zero slots during replay.
module replay_buffer_mc #(
    parameter int P      = 64,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        grst,
    input  logic                        in_valid,
    input  logic [NUM_CH*P-1:0]         data_in,
    output logic [P-1:0]                data_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(NUM_CH)-1:0]   out_ch,
    output logic [$clog2(DEPTH)-1:0]    out_slot,
    output logic                        replay_done,
    output logic                        overflow,
    output logic                        overrun
);
    localparam int CW = $clog2(NUM_CH);
    localparam int SW = $clog2(DEPTH);
    localparam int IW = CW + SW;
    localparam int N  = 1 << IW;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_REPLAY = 1'b1;

    logic            r_grst_q;
    logic            r_wbank;
    logic [0:0]      r_state;
    logic [SW:0]     r_wr_ptr;
    logic [SW:0]     r_fill;
    logic [P-1:0]    r_data_out;
    logic            r_out_valid;
    logic [CW-1:0]   r_out_ch;
    logic [SW-1:0]   r_out_slot;
    logic            r_replay_done;
    logic            r_overflow;
    logic            r_overrun;

    // Flat index {channel, slot}; bank selected by first dimension.
    logic [P-1:0]    r_mem [2][N];

    logic            w_edge;
    logic            w_we;
    logic            w_wsel;
    logic [SW-1:0]   w_wslot;
    logic [N-1:0]    w_nz_st;
    logic [N-1:0]    w_nz_rd;
    logic [IW-1:0]   w_cur;
    logic            w_st_found;
    logic [IW-1:0]   w_st_idx;
    logic            w_rn_found;
    logic [IW-1:0]   w_rn_idx;

    assign w_edge  = grst & ~r_grst_q;
    assign w_we    = in_valid & (w_edge | ~r_wr_ptr[SW]);
    assign w_wsel  = w_edge ? ~r_wbank : r_wbank;
    assign w_wslot = w_edge ? '0 : r_wr_ptr[SW-1:0];
    assign w_cur   = {r_out_ch, r_out_slot};

`ifdef REPLAY_ZERO_SKIP_EN
    logic [1:0][N-1:0] r_nz;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_nz[w_wsel][{CW'(c), w_wslot}] <= |data_in[c*P +: P];
            end
        end
    end

    assign w_nz_st = r_nz[r_wbank];
    assign w_nz_rd = r_nz[~r_wbank];
`else
    assign w_nz_st = '1;
    assign w_nz_rd = '1;
`endif

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_mem[w_wsel][{CW'(c), w_wslot}] <= data_in[c*P +: P];
            end
        end
    end

    // First eligible beat of the bank being closed, and next eligible beat after the current one.
    always_comb begin
        w_st_found = 1'b0;
        w_st_idx   = '0;
        w_rn_found = 1'b0;
        w_rn_idx   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (j < NUM_CH*DEPTH && {1'b0, SW'(j)} < r_wr_ptr && w_nz_st[j]) begin
                w_st_found = 1'b1;
                w_st_idx   = IW'(j);
            end
            if (j < NUM_CH*DEPTH && {1'b0, SW'(j)} < r_fill && w_nz_rd[j] && IW'(j) > w_cur) begin
                w_rn_found = 1'b1;
                w_rn_idx   = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grst_q      <= 1'b0;
            r_wbank       <= 1'b0;
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_fill        <= '0;
            r_data_out    <= '0;
            r_out_valid   <= 1'b0;
            r_out_ch      <= '0;
            r_out_slot    <= '0;
            r_replay_done <= 1'b0;
            r_overflow    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_grst_q      <= grst;
            r_replay_done <= 1'b0;

            if (w_edge) begin
                r_fill   <= r_wr_ptr;
                r_wbank  <= ~r_wbank;
                r_wr_ptr <= {{SW{1'b0}}, in_valid};
            end else if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end else if (in_valid) begin
                r_overflow <= 1'b1;
            end

            // A boundary always wins over the in-flight replay; the closed bank is the old write bank.
            if (w_edge) begin
                if (r_state == S_REPLAY) begin
                    r_overrun <= 1'b1;
                end
                if (w_st_found) begin
                    r_state     <= S_REPLAY;
                    r_out_valid <= 1'b1;
                    r_out_ch    <= w_st_idx[IW-1:SW];
                    r_out_slot  <= w_st_idx[SW-1:0];
                    r_data_out  <= r_mem[r_wbank][w_st_idx];
                end else begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            end else if (r_state == S_REPLAY && out_ready) begin
                if (w_rn_found) begin
                    r_out_ch    <= w_rn_idx[IW-1:SW];
                    r_out_slot  <= w_rn_idx[SW-1:0];
                    r_data_out  <= r_mem[~r_wbank][w_rn_idx];
                end else begin
                    r_state       <= S_IDLE;
                    r_out_valid   <= 1'b0;
                    r_replay_done <= 1'b1;
                end
            end
        end
    end

    assign data_out    = r_data_out;
    assign out_valid   = r_out_valid;
    assign out_ch      = r_out_ch;
    assign out_slot    = r_out_slot;
    assign replay_done = r_replay_done;
    assign overflow    = r_overflow;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_replay_buffer_mc.sv
// Bench for replay_buffer_mc (default build): queue-based model of capture banks and channel-major replay.
module tb_replay_buffer_mc;
    localparam int P      = 64;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 16;

    typedef struct packed {
        logic [P-1:0] d;
        logic [7:0]   ch;
        logic [7:0]   slot;
    } beat_t;

    logic                 clk;
    logic                 rst;
    logic                 grst;
    logic                 in_valid;
    logic [NUM_CH*P-1:0]  data_in;
    logic [P-1:0]         data_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [0:0]           out_ch;
    logic [3:0]           out_slot;
    logic                 replay_done;
    logic                 overflow;
    logic                 overrun;

    int checks;
    int failures;

    logic [NUM_CH*P-1:0] wq[$];
    beat_t exp_q[$];
    beat_t obs_q[$];
    int done_idx;
    int stall_bad;

    replay_buffer_mc #(.P(P), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .grst(grst), .in_valid(in_valid), .data_in(data_in),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_slot(out_slot), .replay_done(replay_done),
        .overflow(overflow), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_CH*P-1:0] rnd_vec();
        logic [NUM_CH*P-1:0] v;
        for (int i = 0; i < NUM_CH*P/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic beat_t cur();
        beat_t b;
        b.d = data_out;
        b.ch = 8'(out_ch);
        b.slot = 8'(out_slot);
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b1; grst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        step(); step();
        rst = 1'b0;
        step();
        wq.delete();
    endtask

    task automatic capture(input logic [NUM_CH*P-1:0] v);
        in_valid = 1'b1;
        data_in = v;
        wq.push_back(v);
        step();
        in_valid = 1'b0;
    endtask

    // Model: closed bank holds the first min(n, DEPTH) beats; replay is channel-major over them.
    task automatic gamma_edge(input logic iv, input logic [NUM_CH*P-1:0] v);
        int fill;
        logic [NUM_CH*P-1:0] vec;
        beat_t b;
        fill = (wq.size() > DEPTH) ? DEPTH : wq.size();
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < fill; s++) begin
                vec = wq[s];
                b.d = vec[c*P +: P];
                b.ch = 8'(c);
                b.slot = 8'(s);
                exp_q.push_back(b);
            end
        end
        wq.delete();
        if (iv) wq.push_back(v);
        grst = 1'b1; in_valid = iv; data_in = v;
        step();
        grst = 1'b0; in_valid = 1'b0;
    endtask

    // Collects accepted beats; mode 0 always ready, 1 pattern 1,0,0, 2 random.
    task automatic collect(input int max_beats, input int mode, input int budget);
        logic r;
        logic stalled;
        beat_t held;
        obs_q.delete();
        done_idx = -1;
        stall_bad = 0;
        for (int i = 0; i < budget; i++) begin
            if (replay_done) begin
                done_idx = i;
                break;
            end
            if (obs_q.size() == max_beats) break;
            case (mode)
                0: r = 1'b1;
                1: r = (i % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            stalled = out_valid && !r;
            held = cur();
            if (out_valid && r) obs_q.push_back(cur());
            step();
            if (stalled && (out_valid !== 1'b1 || cur() !== held)) stall_bad++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [P+10:0] all_out;
        do_reset();
        all_out = {out_valid, data_out, 4'(out_ch), out_slot, replay_done, overflow, overrun};
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_state got %h want 0", all_out);
        end
        for (int i = 0; i < 3; i++) capture(rnd_vec() | 1);
        gamma_edge(1'b0, '0);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_valid got %b want 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        all_out = {out_valid, data_out, 4'(out_ch), out_slot, replay_done, overflow, overrun};
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL async_reset got %h want 0", all_out);
        end
        step();
        rst = 1'b0;
        wq.delete();
        step(); step();
        for (int k = 0; k < 3; k++) begin
            int bad;
            gamma_edge(1'b0, '0);
            bad = 0;
            for (int i = 0; i < 8; i++) begin
                if (out_valid !== 1'b0 || replay_done !== 1'b0) bad++;
                step();
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL idle_edge%0d activity_cycles got %0d want 0", k, bad);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int s = 0; s < 4; s++) capture({P'(s + 5), P'(s + 1)});
        gamma_edge(1'b0, '0);
        collect(1000, 0, 50);
        checks++;
        if (obs_q.size() != 8) begin
            failures++;
            $display("FAIL basic_count got %0d want 8", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].d !== P'(i + 1) || obs_q[i].ch !== 8'(i / 4)) begin
                failures++;
                $display("FAIL basic_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_idx != 8 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got idx=%0d valid=%b want idx=8 valid=0", done_idx, out_valid);
        end
        step();
        checks++;
        if (replay_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got %b want 0", replay_done);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 6; i++) capture(rnd_vec());
        gamma_edge(1'b0, '0);
        collect(1000, 1, 200);
        checks++;
        if (obs_q.size() != exp_q.size() || done_idx < 0) begin
            failures++;
            $display("FAIL bp_count got %0d done=%0d want %0d", obs_q.size(), done_idx, exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stall_bad != 0) begin
            failures++;
            $display("FAIL bp_stall_stable got %0d changes want 0", stall_bad);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) capture(rnd_vec());
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_at_depth got %b want 0", overflow);
        end
        for (int i = 0; i < 4; i++) capture(rnd_vec());
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got %b want 1", overflow);
        end
        gamma_edge(1'b0, '0);
        collect(1000, 2, 400);
        checks++;
        if (obs_q.size() != 2*DEPTH || done_idx < 0) begin
            failures++;
            $display("FAIL ovf_count got %0d done=%0d want %0d", obs_q.size(), done_idx, 2*DEPTH);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL ovf_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overrun();
        beat_t exp_a[$];
        logic [NUM_CH*P-1:0] x;
        do_reset();
        for (int i = 0; i < 4; i++) capture(rnd_vec());
        gamma_edge(1'b0, '0);
        exp_a = exp_q;
        for (int i = 0; i < 3; i++) capture(rnd_vec());
        checks++;
        if (out_valid !== 1'b1 || cur() !== exp_a[0]) begin
            failures++;
            $display("FAIL orun_hold got %h want %h", cur(), exp_a[0]);
        end
        collect(5, 0, 50);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_a[i]) begin
                failures++;
                $display("FAIL orun_a_beat%0d got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_a[i]);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL orun_pre got %b want 0", overrun);
        end
        x = rnd_vec();
        gamma_edge(1'b1, x);
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1 || cur() !== exp_q[0]) begin
            failures++;
            $display("FAIL orun_restart got ovr=%b v=%b beat=%h want ovr=1 v=1 beat=%h", overrun, out_valid, cur(), exp_q[0]);
        end
        collect(1000, 0, 50);
        checks++;
        if (obs_q.size() != 6 || done_idx != 6) begin
            failures++;
            $display("FAIL orun_b_count got %0d done=%0d want 6 done=6", obs_q.size(), done_idx);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL orun_b_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        step();
        gamma_edge(1'b0, '0);
        collect(1000, 0, 50);
        checks++;
        if (obs_q.size() != 2 || done_idx != 2) begin
            failures++;
            $display("FAIL orun_x_count got %0d done=%0d want 2 done=2", obs_q.size(), done_idx);
        end
        for (int i = 0; i < obs_q.size() && i < 2; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].d !== x[i*P +: P] || obs_q[i].slot !== 8'd0) begin
                failures++;
                $display("FAIL orun_x_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, DEPTH + 3);
            for (int i = 0; i < n; i++) capture(rnd_vec());
            gamma_edge(1'b0, '0);
            collect(1000, 2, 400);
            checks++;
            if (obs_q.size() != exp_q.size() || done_idx < 0) begin
                failures++;
                $display("FAIL b2b%0d_count got %0d done=%0d want %0d", r, obs_q.size(), done_idx, exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL b2b%0d_beat%0d got %h want %h", r, i, obs_q[i], exp_q[i]);
                end
            end
            step();
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; grst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_overrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
